// File: rtl/median3x3_filter.sv
// Three-stage pipelined median of a 3x3 window of unsigned samples, one window per cycle.
// Optional MEDIAN_MINMAX_EN adds window min/max outputs aligned with med.
module median3x3_filter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] arr_0_0,
    input  logic [WIDTH-1:0] arr_0_1,
    input  logic [WIDTH-1:0] arr_0_2,
    input  logic [WIDTH-1:0] arr_1_0,
    input  logic [WIDTH-1:0] arr_1_1,
    input  logic [WIDTH-1:0] arr_1_2,
    input  logic [WIDTH-1:0] arr_2_0,
    input  logic [WIDTH-1:0] arr_2_1,
    input  logic [WIDTH-1:0] arr_2_2,
    output logic             out_valid,
`ifdef MEDIAN_MINMAX_EN
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o,
`endif
    output logic [WIDTH-1:0] med
);

    function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] max2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    // Median of three: the larger of min(a,b) and whatever of max(a,b) / c is smaller.
    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [WIDTH-1:0] win [9];
    assign win = '{arr_0_0, arr_0_1, arr_0_2, arr_1_0, arr_1_1, arr_1_2, arr_2_0, arr_2_1, arr_2_2};

    logic [WIDTH-1:0] lo_p1_d [3], mid_p1_d [3], hi_p1_d [3];
    logic [WIDTH-1:0] lo_p1_q [3], mid_p1_q [3], hi_p1_q [3];
    logic [WIDTH-1:0] a_p2_d, b_p2_d, c_p2_d, a_p2_q, b_p2_q, c_p2_q;
    logic [WIDTH-1:0] med_p3_d, med_p3_q;
    logic [2:0]       vld_d, vld_q;
`ifdef MEDIAN_MINMAX_EN
    logic [WIDTH-1:0] min_p2_d, max_p2_d, min_p2_q, max_p2_q;
    logic [WIDTH-1:0] min_p3_d, max_p3_d, min_p3_q, max_p3_q;
`endif

    always_comb begin
        // Stage 1: sort each row into lo <= mid <= hi
        for (int r = 0; r < 3; r++) begin
            lo_p1_d[r]  = min3(win[3*r], win[3*r+1], win[3*r+2]);
            mid_p1_d[r] = med3(win[3*r], win[3*r+1], win[3*r+2]);
            hi_p1_d[r]  = max3(win[3*r], win[3*r+1], win[3*r+2]);
        end
        // Stage 2: column reductions that leave only three median candidates
        a_p2_d = max3(lo_p1_q[0], lo_p1_q[1], lo_p1_q[2]);
        b_p2_d = med3(mid_p1_q[0], mid_p1_q[1], mid_p1_q[2]);
        c_p2_d = min3(hi_p1_q[0], hi_p1_q[1], hi_p1_q[2]);
        // Stage 3: final median of the candidates
        med_p3_d = med3(a_p2_q, b_p2_q, c_p2_q);
        vld_d    = {vld_q[1:0], in_valid};
`ifdef MEDIAN_MINMAX_EN
        min_p2_d = min3(lo_p1_q[0], lo_p1_q[1], lo_p1_q[2]);
        max_p2_d = max3(hi_p1_q[0], hi_p1_q[1], hi_p1_q[2]);
        min_p3_d = min_p2_q;
        max_p3_d = max_p2_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) begin
                lo_p1_q[r]  <= '0;
                mid_p1_q[r] <= '0;
                hi_p1_q[r]  <= '0;
            end
            a_p2_q   <= '0;
            b_p2_q   <= '0;
            c_p2_q   <= '0;
            med_p3_q <= '0;
            vld_q    <= '0;
`ifdef MEDIAN_MINMAX_EN
            min_p2_q <= '0;
            max_p2_q <= '0;
            min_p3_q <= '0;
            max_p3_q <= '0;
`endif
        end else begin
            for (int r = 0; r < 3; r++) begin
                lo_p1_q[r]  <= lo_p1_d[r];
                mid_p1_q[r] <= mid_p1_d[r];
                hi_p1_q[r]  <= hi_p1_d[r];
            end
            a_p2_q   <= a_p2_d;
            b_p2_q   <= b_p2_d;
            c_p2_q   <= c_p2_d;
            med_p3_q <= med_p3_d;
            vld_q    <= vld_d;
`ifdef MEDIAN_MINMAX_EN
            min_p2_q <= min_p2_d;
            max_p2_q <= max_p2_d;
            min_p3_q <= min_p3_d;
            max_p3_q <= max_p3_d;
`endif
        end
    end

    assign med       = med_p3_q;
    assign out_valid = vld_q[2];
`ifdef MEDIAN_MINMAX_EN
    assign min_o     = min_p3_q;
    assign max_o     = max_p3_q;
`endif

endmodule

// File: tb/tb_median3x3_filter.sv
// Directed and random checks of median3x3_filter (WIDTH=8); min/max checked when MEDIAN_MINMAX_EN is defined.
module tb_median3x3_filter;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
    logic         out_valid;
    logic [W-1:0] med;
`ifdef MEDIAN_MINMAX_EN
    logic [W-1:0] min_o, max_o;
`endif

    int checks   = 0;
    int failures = 0;

    median3x3_filter #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .arr_0_0  (a00), .arr_0_1(a01), .arr_0_2(a02),
        .arr_1_0  (a10), .arr_1_1(a11), .arr_1_2(a12),
        .arr_2_0  (a20), .arr_2_1(a21), .arr_2_2(a22),
        .out_valid(out_valid),
`ifdef MEDIAN_MINMAX_EN
        .min_o    (min_o),
        .max_o    (max_o),
`endif
        .med      (med)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // w packs the window row-major with arr_0_0 in the top byte
    task automatic set_win(input logic [9*W-1:0] w, input logic v);
        {a00, a01, a02, a10, a11, a12, a20, a21, a22} = w;
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] m, input logic [W-1:0] mn,
                              input logic [W-1:0] mx);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_med"}, {24'd0, med}, {24'd0, m});
`ifdef MEDIAN_MINMAX_EN
        check({tag, "_min"}, {24'd0, min_o}, {24'd0, mn});
        check({tag, "_max"}, {24'd0, max_o}, {24'd0, mx});
`else
        if (mn > mx) $display("note: inconsistent min/max for %s", tag);
`endif
    endtask

    // Run one window through the pipe with idle cycles around it
    task automatic single(input string tag, input logic [9*W-1:0] w, input logic [W-1:0] m,
                          input logic [W-1:0] mn, input logic [W-1:0] mx);
        set_win(w, 1'b1);
        step();
        set_win('0, 1'b0);
        step();
        step();
        expect_out(tag, m, mn, mx);
        step();
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [W-1:0] sw_median(input logic [W-1:0] v [9]);
        logic [W-1:0] s [9];
        logic [W-1:0] t;
        s = v;
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        return s[4];
    endfunction

    logic [W-1:0] exp_med [1000];
    logic [W-1:0] rv [9];

    initial begin
        reset_n = 1'b0;
        set_win({8'd17, 8'd200, 8'd3, 8'd99, 8'd250, 8'd1, 8'd64, 8'd128, 8'd7}, 1'b1);
        step();
        step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_med", {24'd0, med}, 32'd0);
`ifdef MEDIAN_MINMAX_EN
        check("rst_min", {24'd0, min_o}, 32'd0);
        check("rst_max", {24'd0, max_o}, 32'd0);
`endif
        set_win('0, 1'b0);
        reset_n = 1'b1;
        step();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // Latency: nothing before the third edge, result after it
        set_win({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b1);
        step();
        set_win('0, 1'b0);
        step();
        check("lat_early", {31'd0, out_valid}, 32'd0);
        step();
        expect_out("ordered", 8'd5, 8'd1, 8'd9);
        step();
        check("ordered_drop", {31'd0, out_valid}, 32'd0);

        single("scatter", {8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4}, 8'd5, 8'd1, 8'd9);
        single("equal", {9{8'd42}}, 8'd42, 8'd42, 8'd42);
        single("hi_ext", {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
               8'd255, 8'd0, 8'd255);
        single("lo_ext", {8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0},
               8'd0, 8'd0, 8'd255);
        single("column", {8'd50, 8'd10, 8'd90, 8'd60, 8'd20, 8'd80, 8'd70, 8'd30, 8'd40},
               8'd50, 8'd10, 8'd90);

        // Back-to-back windows give back-to-back results
        set_win({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 1'b1);
        step();
        set_win({8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19}, 1'b1);
        step();
        set_win({8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29}, 1'b1);
        step();
        expect_out("stream0", 8'd5, 8'd1, 8'd9);
        set_win('0, 1'b0);
        step();
        expect_out("stream1", 8'd15, 8'd11, 8'd19);
        step();
        expect_out("stream2", 8'd25, 8'd21, 8'd29);
        step();
        check("stream_end", {31'd0, out_valid}, 32'd0);

        // Reset one cycle after issuing a window discards it
        set_win({8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5}, 1'b1);
        step();
        set_win('0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midrst_%0d", k), {31'd0, out_valid}, 32'd0);
            step();
        end

        // Random stream against a software sort
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                for (int k = 0; k < 9; k++) rv[k] = W'($urandom_range(0, 255));
                if (i % 7 == 3) for (int k = 0; k < 9; k++) rv[k] = rv[k] & 8'h0F;
                exp_med[i] = sw_median(rv);
                set_win({rv[0], rv[1], rv[2], rv[3], rv[4], rv[5], rv[6], rv[7], rv[8]}, 1'b1);
            end else begin
                set_win('0, 1'b0);
            end
            step();
            if (i >= 2) begin
                check($sformatf("rnd_v%0d", i - 2), {31'd0, out_valid}, 32'd1);
                check($sformatf("rnd_m%0d", i - 2), {24'd0, med}, {24'd0, exp_med[i-2]});
            end
        end
        step();
        check("rnd_end", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
